// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: address width,
// the hard-wired zero register and the requester indices.
package rf_write_arbiter_pkg;

    localparam int         ADDR_W   = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic       REQ_ALU  = 1'b0;
    localparam logic       REQ_MEM  = 1'b1;

endpackage

// File: rtl/MUX2X5.sv
// Existing 2:1 five-bit register-address mux sitting in front of the
// register file.
module MUX2X5 (
    input  logic [4:0] A0,
    input  logic [4:0] A1,
    input  logic       S,
    output logic [4:0] Y
);

    assign Y = S ? A1 : A0;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the ALU and load
// writeback paths: one holding entry per requester, round-robin grant.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [DW-1:0]     in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [DW-1:0]     in1_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic              rf_sel,
    output logic              busy
);

    logic              pend0_q, pend0_d, pend1_q, pend1_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DW-1:0]     data0_q, data0_d, data1_q, data1_d;
    logic              rr_q, rr_d;
    logic              rf_we_q, rf_we_d, rf_sel_q, rf_sel_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]     rf_wdata_q, rf_wdata_d;

    logic              gnt0, gnt1, gnt_valid, gnt_idx;
    logic              acc0, acc1;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DW-1:0]     gnt_data;

    // Grant and ready are functions of registered state only, so ready never
    // depends combinationally on the requester's valid.
    always_comb begin
        gnt0      = pend0_q & (~pend1_q | (rr_q == REQ_ALU));
        gnt1      = pend1_q & (~pend0_q | (rr_q == REQ_MEM));
        gnt_valid = gnt0 | gnt1;
        gnt_idx   = gnt1 ? REQ_MEM : REQ_ALU;
    end

    assign in0_ready = ~pend0_q | gnt0;
    assign in1_ready = ~pend1_q | gnt1;
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;
    assign busy      = pend0_q | pend1_q;

    MUX2X5 u_addr_mux (
        .A0 (addr0_q),
        .A1 (addr1_q),
        .S  (gnt_idx),
        .Y  (gnt_addr)
    );

    assign gnt_data = gnt_idx ? data1_q : data0_q;

    // NOTE: every signal gets a value on every path through this block;
    // a missing default here would infer a latch.
    always_comb begin
        pend0_d    = acc0 | (pend0_q & ~gnt0);
        pend1_d    = acc1 | (pend1_q & ~gnt1);
        addr0_d    = acc0 ? in0_addr : addr0_q;
        addr1_d    = acc1 ? in1_addr : addr1_q;
        data0_d    = acc0 ? in0_data : data0_q;
        data1_d    = acc1 ? in1_data : data1_q;
        rr_d       = rr_q;
        if (pend0_q & pend1_q) begin
            rr_d = ~gnt_idx;
        end
        rf_we_d    = gnt_valid & (gnt_addr != REG_ZERO);
        rf_waddr_d = gnt_valid ? gnt_addr : REG_ZERO;
        rf_wdata_d = gnt_valid ? gnt_data : '0;
        rf_sel_d   = gnt_valid ? gnt_idx  : rf_sel_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            rr_q       <= REQ_ALU;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= REG_ZERO;
            rf_wdata_q <= '0;
            rf_sel_q   <= REQ_ALU;
        end else begin
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            rr_q       <= rr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_sel_q   <= rf_sel_d;
        end
    end

    // NOTE: payload registers are left unreset; they are only observed while
    // the matching pend flag is set, which reset clears.
    always_ff @(posedge clk) begin
        addr0_q <= addr0_d;
        addr1_q <= addr1_d;
        data0_q <= data0_d;
        data1_q <= data1_d;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_sel   = rf_sel_q;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

- Shares the register file's single write port between two writeback requesters:
  - requester 0: ALU/execute result;
  - requester 1: memory-load result.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter picks one buffered write per cycle and drives the registered write-port signals.
- Also drives the select of the 2:1 five-bit register-address mux in front of the register file.

## Interface
Parameters:
- DW, 32, data width of a register write.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in0_valid  in  1  requester 0 has a write.
- in0_ready  out  1  requester 0 transfer accepted this cycle when in0_valid & in0_ready.
- in0_addr  in  5  requester 0 destination register.
- in0_data  in  DW  requester 0 write data.
- in1_valid, in1_ready, in1_addr, in1_data: same as requester 0, for requester 1.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  DW  register-file write data (registered).
- rf_sel  out  1  source of the current write: 0 = requester 0, 1 = requester 1 (registered).
- busy  out  1  OR of both pending flags.

## Operation
- Per requester i there is one holding entry: pend_i, addr_i, data_i.
  - in_i_ready = ~pend_i | gnt_i.
  - ready depends only on registers, never on in_i_valid.
- Accept: in_i_valid & in_i_ready at an edge loads addr_i/data_i and sets pend_i. If gnt_i occurs in the same cycle, pend_i stays 1 with the new contents.
- Grant (combinational from registers):
  - only pend_0 set: gnt_0;
  - only pend_1 set: gnt_1;
  - both set: grant requester rr;
  - neither set: no grant.
- Round-robin pointer rr:
  - when both are pending and a grant is made, rr <= index of the loser;
  - otherwise rr holds.
- Granted entry: pend_i cleared at the edge unless it is refilled by a simultaneous accept.
- Output registers at each edge:
  - rf_we <= grant & (granted addr != 0);
  - rf_waddr <= granted addr, or 0 when there is no grant;
  - rf_wdata <= granted data, or 0 when there is no grant;
  - rf_sel <= granted index, or holds when there is no grant.
- Register 0: a write to address 0 consumes its grant slot and is dropped, so rf_we stays 0.
- Same destination from both requesters: no merging. Both writes occur in grant order, and the later one wins in the register file.

## Timing
- Reset values:
  - pend_0 = pend_1 = 0, rr = 0;
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, rf_sel = 0, busy = 0;
  - in0_ready = in1_ready = 1.
- Latency: accept at edge E, grant in the cycle after E, rf_we high in the cycle after edge E+1. Uncontended latency is 2 edges.
- Throughput: one write per cycle total.
  - An uncontended requester can sustain one transfer per cycle.
  - Under contention each requester gets every other slot.
- Starvation bound: a pending entry is granted within 2 cycles.
- Reset mid-operation:
  - pending entries are discarded with no write issued;
  - outputs take reset values at the reset edge;
  - rf_we is 0 in the cycle after the reset edge.

## Structure
- Shared package or header holds:
  - register-address width constant, 5;
  - REG_ZERO = 5'd0;
  - requester index constants REQ_ALU = 0 and REQ_MEM = 1.
- The address path instantiates the existing MUX2X5 module:
  - A0 = addr_0, A1 = addr_1, S = granted index;
  - its output feeds the rf_waddr register.
- The data path uses an inline DW-bit 2:1 select.
- No other sub-modules.

## Test plan
- Reset then idle: rst high for 2 cycles → all outputs 0, both readies 1, busy 0; rf_we stays 0 for 10 idle cycles.
- Single write: in0_valid with addr 5, data 0x12345678 for one cycle → exactly one rf_we pulse, 2 edges later, with rf_waddr=5, rf_wdata=0x12345678, rf_sel=0.
- Contention: both requesters valid every cycle for 8 cycles with distinct addresses →
  - rf_sel alternates 0,1,0,1… starting at 0;
  - each requester is deasserted-ready on alternate cycles;
  - no write is lost or duplicated.
- Register zero: in1 writes addr 0, data 0xFFFFFFFF → in1 handshake completes, busy pulses, rf_we never asserts.
- Same address: in0 and in1 both target addr 7 in the same cycle, data 0xA and 0xB → two rf_we pulses on consecutive cycles, 0xA first then 0xB.
- Reset mid-operation: both entries pending, rst asserted one cycle → no rf_we in the following cycle, busy 0, rr 0.
